// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Brief    : Shared AES constants, GF(2^8) helpers and FSM encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int         c_STATE_W = 128;
    localparam int         c_COL_W   = 32;
    localparam logic [7:0] c_GF_RED  = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? c_GF_RED : 8'h00);
    endfunction

    // Each constant multiply reuses the x2/x4/x8 chain, keeping depth at three xtimes.
    function automatic logic [7:0] gmul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mix_column.sv
`default_nettype none
// ============================================================================
//  Module   : inv_mix_column
//  Brief    : Combinational InvMixColumns transform of one 32-bit column.
//  Revision : 1.0 - initial release
// ============================================================================
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] w_s0, w_s1, w_s2, w_s3;

    assign w_s0 = col_i[31:24];
    assign w_s1 = col_i[23:16];
    assign w_s2 = col_i[15:8];
    assign w_s3 = col_i[7:0];

    assign col_o[31:24] = gmul0e(w_s0) ^ gmul0b(w_s1) ^ gmul0d(w_s2) ^ gmul09(w_s3);
    assign col_o[23:16] = gmul09(w_s0) ^ gmul0e(w_s1) ^ gmul0b(w_s2) ^ gmul0d(w_s3);
    assign col_o[15:8]  = gmul0d(w_s0) ^ gmul09(w_s1) ^ gmul0e(w_s2) ^ gmul0b(w_s3);
    assign col_o[7:0]   = gmul0b(w_s0) ^ gmul0d(w_s1) ^ gmul09(w_s2) ^ gmul0e(w_s3);

endmodule
`default_nettype wire

// File: rtl/inv_round_mix.sv
`default_nettype none
// ============================================================================
//  Module   : inv_round_mix
//  Brief    : AddRoundKey then column-serial InvMixColumns, with final-round bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module inv_round_mix
    import aes_pkg::*;
#(
    parameter int NUM_COLS = 4
)(
    input  logic         clock,
    input  logic         reset,
    input  logic         startTransition,
    input  logic         skipMix,
    input  logic [127:0] inputData,
    input  logic [127:0] roundKey,
    output logic [127:0] outputData,
    output logic         dataValid,
    output logic         busy
);

    state_t         state_q;
    logic [1:0]     col_cnt_q;
    logic [127:0]   work_q;
    logic [127:0]   out_q;
    logic           valid_q;
    logic           busy_q;

    logic [31:0]    w_col_in;
    logic [31:0]    w_col_out;
    logic [127:0]   work_d;

    // Column 0 sits in the most significant word of the state.
    always_comb begin
        w_col_in = work_q[c_STATE_W-1 -: c_COL_W];
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_cnt_q == c[1:0]) begin
                w_col_in = work_q[c_STATE_W-1-c*c_COL_W -: c_COL_W];
            end
        end
    end

    inv_mix_column u_inv_mix_column (
        .col_i (w_col_in),
        .col_o (w_col_out)
    );

    always_comb begin
        work_d = work_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_cnt_q == c[1:0]) begin
                work_d[c_STATE_W-1-c*c_COL_W -: c_COL_W] = w_col_out;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            col_cnt_q <= 2'd0;
            work_q    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (startTransition) begin
                        work_q    <= inputData ^ roundKey;
                        col_cnt_q <= 2'd0;
                        busy_q    <= 1'b1;
                        state_q   <= skipMix ? ST_DONE : ST_MIX;
                    end
                end
                ST_MIX: begin
                    work_q    <= work_d;
                    col_cnt_q <= col_cnt_q + 2'd1;
                    if (col_cnt_q == 2'(NUM_COLS - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    out_q   <= work_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign outputData = out_q;
    assign dataValid  = valid_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_round_mix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_round_mix
//  Brief    : Self-checking bench for inv_round_mix against a latency-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inv_round_mix;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         startTransition = 1'b0;
    logic         skipMix = 1'b0;
    logic [127:0] inputData = '0;
    logic [127:0] roundKey = '0;
    logic [127:0] outputData;
    logic         dataValid;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    localparam logic [127:0] c_MIX_IN  = 128'h8e4da1bc9fdc589d4d7ebdf8d5d5d7d6;
    localparam logic [127:0] c_MIX_OUT = 128'hdb135345f20a225c2d26314cd4d4d4d5;
    localparam logic [127:0] c_BYP_IN  = 128'h1a3174470b1b226e59084e3c540e1f00;
    localparam logic [127:0] c_BYP_OUT = 128'he5ce8bb8f4e4dd91a6f7b1c3abf1e0ff;
    localparam logic [127:0] c_ID_IN   = 128'h01010101c6c6c6c601010101c6c6c6c6;
    localparam logic [127:0] c_ONES    = {128{1'b1}};

    inv_round_mix #(.NUM_COLS(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .startTransition (startTransition),
        .skipMix         (skipMix),
        .inputData       (inputData),
        .roundKey        (roundKey),
        .outputData      (outputData),
        .dataValid       (dataValid),
        .busy            (busy)
    );

    always #10 clock = ~clock;

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix_state(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(coef[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Model: an accepted request completes a fixed number of edges later.
    logic         m_busy = 1'b0;
    logic         m_valid = 1'b0;
    int           m_left = 0;
    logic [127:0] m_res = '0;
    logic [127:0] m_out = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
            m_out   <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_out   <= m_res;
                    m_valid <= 1'b1;
                    m_busy  <= 1'b0;
                end
                m_left <= m_left - 1;
            end else if (startTransition) begin
                m_res  <= skipMix ? (inputData ^ roundKey) : inv_mix_state(inputData ^ roundKey);
                m_left <= skipMix ? 1 : 5;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_valid", 128'(dataValid), 128'(m_valid));
            chk("model_busy",  128'(busy),      128'(m_busy));
            chk("model_out",   outputData,      m_out);
        end
    end

    task automatic run_op(input string name, input logic [127:0] din, input logic [127:0] key,
                          input logic skip, input logic [127:0] exp, input int lat);
        @(negedge clock);
        #2;
        inputData = din; roundKey = key; skipMix = skip; startTransition = 1'b1;
        @(posedge clock);
        #1;
        startTransition = 1'b0;
        inputData = {$urandom, $urandom, $urandom, $urandom};
        roundKey  = {$urandom, $urandom, $urandom, $urandom};
        skipMix   = 1'($urandom);
        chk({name, "_busy_e0"}, 128'(busy), 128'(1));
        for (int k = 1; k < lat; k++) begin
            @(posedge clock);
            #1;
            chk({name, "_dv_early"}, 128'(dataValid), 128'(0));
            chk({name, "_busy_mid"}, 128'(busy), 128'(1));
        end
        @(posedge clock);
        #1;
        chk({name, "_dv"},   128'(dataValid), 128'(1));
        chk({name, "_out"},  outputData, exp);
        chk({name, "_busy_done"}, 128'(busy), 128'(0));
        @(posedge clock);
        #1;
        chk({name, "_dv_pulse"}, 128'(dataValid), 128'(0));
        chk({name, "_hold"}, outputData, exp);
        skipMix = 1'b0;
    endtask

    initial begin
        int pulses;
        int pos [$];
        logic [127:0] seen;

        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        chk("rst_out",  outputData, 128'h0);
        chk("rst_dv",   128'(dataValid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;

        run_op("mix",      c_MIX_IN, 128'h0,  1'b0, c_MIX_OUT, 5);
        run_op("bypass",   c_BYP_IN, c_ONES,  1'b1, c_BYP_OUT, 1);
        run_op("identity", c_ID_IN,  128'h0,  1'b0, c_ID_IN,   5);
        run_op("keymix",   c_MIX_IN ^ c_BYP_IN, c_BYP_IN, 1'b0, c_MIX_OUT, 5);

        // Second start at E2 must be ignored.
        @(negedge clock);
        #2;
        inputData = c_MIX_IN; roundKey = '0; skipMix = 1'b0; startTransition = 1'b1;
        @(posedge clock);
        #1;
        startTransition = 1'b0;
        @(posedge clock);
        #1;
        inputData = c_BYP_IN; roundKey = c_ONES; startTransition = 1'b1;
        @(posedge clock);
        #1;
        startTransition = 1'b0;
        pulses = 0; seen = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (dataValid) begin pulses++; seen = outputData; end
        end
        chk("busy_start_pulses", 128'(pulses), 128'(1));
        chk("busy_start_out",    seen, c_MIX_OUT);

        // Reset at E3 with start also asserted: reset wins, nothing completes.
        @(negedge clock);
        #2;
        inputData = c_ID_IN; roundKey = '0; startTransition = 1'b1;
        @(posedge clock);
        #1;
        startTransition = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1; startTransition = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_mid_out",  outputData, 128'h0);
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_dv",   128'(dataValid), 128'(0));
        reset = 1'b0; startTransition = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (dataValid) pulses++;
        end
        chk("rst_mid_no_dv", 128'(pulses), 128'(0));
        run_op("after_rst", c_BYP_IN, c_ONES, 1'b1, c_BYP_OUT, 1);

        // Held start: completions every six edges.
        @(negedge clock);
        #2;
        inputData = c_MIX_IN; roundKey = '0; skipMix = 1'b0; startTransition = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (dataValid) begin
                pos.push_back(i);
                chk("held_out", outputData, c_MIX_OUT);
            end
        end
        startTransition = 1'b0;
        chk("held_count", 128'(pos.size()), 128'(3));
        if (pos.size() == 3) begin
            chk("held_e5",  128'(pos[0]), 128'(5));
            chk("held_e11", 128'(pos[1]), 128'(11));
            chk("held_e17", 128'(pos[2]), 128'(17));
        end
        repeat (10) @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inv_round_mix.md
# inv_round_mix

Sequential AddRoundKey + InvMixColumns stage of the AES decryption round, directly downstream of `inv_sub_byte`. It takes the 128-bit inverse-substituted state, XORs in the round key, then applies InvMixColumns one 32-bit column per clock. A bypass input skips the mix for the final decryption round. Completion is signalled with a one-cycle `dataValid` pulse and a held result.

## Interface
- `NUM_COLS`, 4: columns per state; fixed for AES-128, not meant to be overridden.
- `clock` input 1: system clock (50 MHz).
- `reset` input 1: synchronous, active-high.
- `startTransition` input 1: level-sampled start request, accepted only in IDLE.
- `skipMix` input 1: sampled with start; 1 = AddRoundKey only (final round).
- `inputData` input 128: state from `inv_sub_byte`; column 0 = [127:96], row 0 = MSB byte of each column.
- `roundKey` input 128: round key, same byte ordering; sampled with start.
- `outputData` output 128: result, held until the next completion.
- `dataValid` output 1: one-cycle pulse when `outputData` has just updated.
- `busy` output 1: high from the accept edge until completion.

## Operation
- FSM states: IDLE, MIX, DONE.
- IDLE:
  - At a clock edge with `startTransition`=1, latch `work = inputData ^ roundKey` and `skipMix`.
  - Clear `colCount`, assert `busy`.
  - Go to MIX, or to DONE when `skipMix`=1.
- MIX: each edge replaces column `colCount` of `work` with InvMixColumn(column) and increments `colCount` (2 bits).
  - Matrix rows: {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
  - Arithmetic in GF(2^8) with polynomial 0x11B; xtime = shift left, then XOR 0x1B if bit 7 was set.
  - After column 3 (`colCount` wraps 3→0), go to DONE.
- DONE (one cycle): `outputData <= work`, `dataValid <= 1`, `busy <= 0`, go to IDLE.
- `startTransition` in MIX or DONE is ignored; no queuing.
- Holding `startTransition` high gives back-to-back operations.
- `inputData`, `roundKey` and `skipMix` may change freely after the accept edge.
- Reset at any time, including mid-MIX:
  - Next edge forces IDLE, `outputData`=0, `dataValid`=0, `busy`=0, `colCount`=0, `work`=0.
  - The in-flight result is discarded.
- Simultaneous reset and start: reset wins; start is not accepted.

## Timing
- Reset values: `outputData`=128'h0, `dataValid`=0, `busy`=0.
- Accept edge E0: `busy`=1 after E0.
- Mix path:
  - Columns computed on E1–E4.
  - `outputData`/`dataValid` update on E5.
  - Latency 5 clocks from the accept edge; throughput one block per 6 clocks with start held high (re-accept at E6).
- Bypass path:
  - `outputData`/`dataValid` update on E1.
  - Re-accept at E2.
- `dataValid` is high for exactly one cycle per accepted operation.
- `outputData` is constant between `dataValid` pulses.
- Critical path: one column of GF constant multiplies (xtime chain ≤3 deep) plus a 4-input XOR per byte.

## Structure
- Shared package/include `aes_pkg`:
  - GF reduction constant 8'h1B.
  - xtime and GF multiply-by-{09,0b,0d,0e} functions.
  - State width 128 and column width 32 constants.
  - FSM state encodings.
- Sub-module `inv_mix_column`: combinational 32-in/32-out single-column transform. Instantiated once and muxed by `colCount`.
- Top-level holds the FSM, the counter, `work` and the output registers.

## Test plan
- Mix vector:
  - Stimulus: `inputData`=128'h8e4da1bc9fdc589d4d7ebdf8d5d5d7d6, `roundKey`=0, `skipMix`=0, start pulse.
  - Required: `outputData`=128'hdb135345f20a225c2d26314cd4d4d4d5 with `dataValid` at E5; `busy` high E0–E4.
- Key XOR + bypass:
  - Stimulus: `inputData`=128'h1a3174470b1b226e59084e3c540e1f00, `roundKey`=128'hffffffffffffffffffffffffffffffff, `skipMix`=1.
  - Required: `outputData`=128'he5ce8bb8f4e4dd91a6f7b1c3abf1e0ff at E1.
- Identity columns:
  - Stimulus: `inputData`=128'h01010101c6c6c6c601010101c6c6c6c6, `roundKey`=0.
  - Required: output equals input at E5.
- Start while busy:
  - Stimulus: second start pulse at E2 with different data.
  - Required: ignored; exactly one `dataValid`; result matches the first operation.
- Reset mid-operation:
  - Stimulus: assert `reset` at E3.
  - Required: `outputData`=0, `dataValid` never pulses, `busy`=0; a new start afterwards completes normally.
- Held start:
  - Stimulus: `startTransition` tied high for 20 cycles.
  - Required: `dataValid` at E5, E11, E17, each with the correct result.
